// File: rtl/nbody_step_engine.sv
// N-body time-step sequencer: streams ordered (i, j) pairs to an external force pipeline,
// accumulates the returned forces and applies a saturating semi-implicit Euler update.
module nbody_step_engine #(
  parameter int unsigned N        = 16,
  parameter int unsigned AW       = $clog2(N),
  parameter int unsigned W        = 16,
  parameter int unsigned MW       = 16,
  parameter int unsigned FW       = 32,
  parameter int unsigned DT_SHIFT = 4,
  parameter int unsigned BW       = 4 * W + MW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          num_steps,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          step_count,
  input  logic                 host_we,
  input  logic [AW-1:0]        host_addr,
  input  logic [BW-1:0]        host_wdata,
  output logic [BW-1:0]        host_rdata,
  output logic                 fu_valid,
  input  logic                 fu_ready,
  output logic [BW-1:0]        fu_body_i,
  output logic [BW-1:0]        fu_body_j,
  input  logic                 fu_res_valid,
  input  logic signed [FW-1:0] fu_fx,
  input  logic signed [FW-1:0] fu_fy
);
  localparam int unsigned AccW = FW + AW;
  localparam int unsigned EW   = AccW + 2;
  localparam logic [AW-1:0] Last      = AW'(N - 1);
  localparam logic [AW-1:0] LastIssue = AW'(N - 2);
  localparam logic signed [EW-1:0] SatMax = {{(EW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [EW-1:0] SatMin = {{(EW - W + 1){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StLoadI, StIssue, StDrain, StUpdate, StSwap, StDone} state_e;

  state_e                 state_q, state_d;
  logic                   bank_q, bank_d;
  logic [AW-1:0]          i_q, i_d, j_q, j_d, issued_q, issued_d, recv_q, recv_d;
  logic signed [AccW-1:0] ax_q, ax_d, ay_q, ay_d;
  logic [15:0]            nsteps_q, nsteps_d, sc_q, sc_d;
  logic [BW-1:0]          body_i_q, body_i_d, rdata_q;

  logic [BW-1:0] mem0 [N];
  logic [BW-1:0] mem1 [N];
  logic [BW-1:0] cur_i_word, cur_j_word, cur_host_word, upd_word;
  logic [AW-1:0] j_inc, j_nxt;
  logic          upd_we, host_wr;

  assign cur_i_word    = bank_q ? mem1[i_q] : mem0[i_q];
  assign cur_j_word    = bank_q ? mem1[j_q] : mem0[j_q];
  assign cur_host_word = bank_q ? mem1[host_addr] : mem0[host_addr];
  assign host_wr       = host_we && !busy && !reset;

  // Host writes the current bank; integration results always land in the other one.
  always_ff @(posedge clk) begin
    if (host_wr && !bank_q) mem0[host_addr] <= host_wdata;
    else if (upd_we && bank_q && !reset) mem0[i_q] <= upd_word;
  end

  always_ff @(posedge clk) begin
    if (host_wr && bank_q) mem1[host_addr] <= host_wdata;
    else if (upd_we && !bank_q && !reset) mem1[i_q] <= upd_word;
  end

  function automatic logic signed [W-1:0] sat(input logic signed [EW-1:0] v);
    if (v > SatMax) return SatMax[W-1:0];
    else if (v < SatMin) return SatMin[W-1:0];
    else return v[W-1:0];
  endfunction

  logic signed [W-1:0]  bx, by, bvx, bvy, x_new, y_new, vx_new, vy_new;
  logic signed [EW-1:0] vx_w, vy_w, x_w, y_w;

  always_comb begin
    bx     = body_i_q[MW + 3 * W +: W];
    by     = body_i_q[MW + 2 * W +: W];
    bvx    = body_i_q[MW + W +: W];
    bvy    = body_i_q[MW +: W];
    vx_w   = EW'(bvx) + EW'(ax_q >>> DT_SHIFT);
    vy_w   = EW'(bvy) + EW'(ay_q >>> DT_SHIFT);
    vx_new = sat(vx_w);
    vy_new = sat(vy_w);
    // Position uses the already-updated velocity (semi-implicit Euler).
    x_w    = EW'(bx) + EW'(vx_new >>> DT_SHIFT);
    y_w    = EW'(by) + EW'(vy_new >>> DT_SHIFT);
    x_new  = sat(x_w);
    y_new  = sat(y_w);
    upd_word = {x_new, y_new, vx_new, vy_new, body_i_q[MW-1:0]};
  end

  assign j_inc = j_q + AW'(1);
  assign j_nxt = (j_inc == i_q) ? j_q + AW'(2) : j_inc;

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    i_d      = i_q;
    j_d      = j_q;
    issued_d = issued_q;
    recv_d   = recv_q;
    ax_d     = ax_q;
    ay_d     = ay_q;
    nsteps_d = nsteps_q;
    sc_d     = sc_q;
    body_i_d = body_i_q;
    upd_we   = 1'b0;
    if ((state_q == StIssue || state_q == StDrain) && fu_res_valid) begin
      ax_d   = ax_q + AccW'(fu_fx);
      ay_d   = ay_q + AccW'(fu_fy);
      recv_d = recv_q + AW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          nsteps_d = num_steps;
          sc_d     = '0;
          i_d      = '0;
          state_d  = (num_steps == 16'd0) ? StDone : StLoadI;
        end
      end
      StLoadI: begin
        body_i_d = cur_i_word;
        ax_d     = '0;
        ay_d     = '0;
        issued_d = '0;
        recv_d   = '0;
        j_d      = (i_q == '0) ? AW'(1) : '0;
        state_d  = StIssue;
      end
      StIssue: begin
        if (fu_ready) begin
          issued_d = issued_q + AW'(1);
          j_d      = j_nxt;
          // A zero-latency result may complete in the same cycle as the last issue.
          if (issued_q == LastIssue) state_d = (recv_d == Last) ? StUpdate : StDrain;
        end
      end
      StDrain: begin
        if (recv_d == Last) state_d = StUpdate;
      end
      StUpdate: begin
        upd_we = 1'b1;
        if (i_q == Last) begin
          state_d = StSwap;
        end else begin
          i_d     = i_q + AW'(1);
          state_d = StLoadI;
        end
      end
      StSwap: begin
        bank_d = ~bank_q;
        sc_d   = sc_q + 16'd1;
        if (sc_d == nsteps_q) begin
          state_d = StDone;
        end else begin
          i_d     = '0;
          state_d = StLoadI;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      bank_q   <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      issued_q <= '0;
      recv_q   <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      nsteps_q <= '0;
      sc_q     <= '0;
      body_i_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      i_q      <= i_d;
      j_q      <= j_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      nsteps_q <= nsteps_d;
      sc_q     <= sc_d;
      body_i_q <= body_i_d;
      rdata_q  <= cur_host_word;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign step_count = sc_q;
  assign host_rdata = rdata_q;
  assign fu_valid   = (state_q == StIssue);
  assign fu_body_i  = fu_valid ? body_i_q : '0;
  assign fu_body_j  = fu_valid ? cur_j_word : '0;

endmodule

// File: tb/tb_nbody_step_engine.sv
// Directed bench: an N=4 engine driven by a difference-force model, plus an N=16 engine
// exercised only through its host load/readout path.
module tb_nbody_step_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests, n_fail;
  int lat;

  logic               reset, start, busy, done, host_we, fu_valid, fu_ready, fu_res_valid;
  logic [15:0]        num_steps, step_count;
  logic [1:0]         host_addr;
  logic [79:0]        host_wdata, host_rdata, fu_body_i, fu_body_j;
  logic signed [31:0] fu_fx, fu_fy;

  logic        h_start, h_busy, h_done, h_we, h_fu_valid;
  logic [15:0] h_num_steps, h_step_count;
  logic [3:0]  h_addr;
  logic [79:0] h_wdata, h_rdata, h_fu_body_i, h_fu_body_j;

  nbody_step_engine #(.N(4)) dut (
    .clk(clk), .reset(reset), .start(start), .num_steps(num_steps), .busy(busy), .done(done),
    .step_count(step_count), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .fu_valid(fu_valid),
    .fu_ready(fu_ready), .fu_body_i(fu_body_i), .fu_body_j(fu_body_j),
    .fu_res_valid(fu_res_valid), .fu_fx(fu_fx), .fu_fy(fu_fy)
  );

  nbody_step_engine dut16 (
    .clk(clk), .reset(reset), .start(h_start), .num_steps(h_num_steps), .busy(h_busy),
    .done(h_done), .step_count(h_step_count), .host_we(h_we), .host_addr(h_addr),
    .host_wdata(h_wdata), .host_rdata(h_rdata), .fu_valid(h_fu_valid), .fu_ready(1'b0),
    .fu_body_i(h_fu_body_i), .fu_body_j(h_fu_body_j), .fu_res_valid(1'b0), .fu_fx('0),
    .fu_fy('0)
  );

  function automatic logic signed [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [79:0] mk(input int x, input int y, input int vx, input int vy,
                                     input int m);
    return {16'(x), 16'(y), 16'(vx), 16'(vy), 16'(m)};
  endfunction

  // Force model: fx = xj - xi, fy = yj - yi, delivered lat cycles after the handshake.
  logic               pv  [8];
  logic signed [31:0] pfx [8];
  logic signed [31:0] pfy [8];
  always @(posedge clk) begin
    pv[0]  <= fu_valid && fu_ready && !reset;
    pfx[0] <= sx(fu_body_j[79:64]) - sx(fu_body_i[79:64]);
    pfy[0] <= sx(fu_body_j[63:48]) - sx(fu_body_i[63:48]);
    for (int k = 1; k < 8; k++) begin
      pv[k]  <= pv[k-1];
      pfx[k] <= pfx[k-1];
      pfy[k] <= pfy[k-1];
    end
  end
  assign fu_res_valid = pv[lat-1];
  assign fu_fx        = pfx[lat-1];
  assign fu_fy        = pfy[lat-1];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int xs[4], input int vxs[4]);
    for (int k = 0; k < 4; k++) begin
      host_we    = 1'b1;
      host_addr  = 2'(k);
      host_wdata = mk(xs[k], 0, vxs[k], 0, 10 + k);
      @(negedge clk);
    end
    host_we = 1'b0;
  endtask

  task automatic check_bodies(input string tag, input int xs[4], input int vxs[4]);
    for (int k = 0; k < 4; k++) begin
      host_addr = 2'(k);
      @(negedge clk);
      check($sformatf("%s body%0d", tag, k), host_rdata, mk(xs[k], 0, vxs[k], 0, 10 + k));
    end
  endtask

  // Starts a run and follows it to IDLE, recording done pulses, handshakes and stall stability.
  task automatic run(input int steps, input bit alt, output int dones, output int hs,
                     output int cyc, output bit stable_ok, output bit seq_ok);
    logic [79:0] pi, pj;
    logic [15:0] last_sc;
    bit          stalled, rdy;
    dones = 0; hs = 0; stable_ok = 1'b1; seq_ok = 1'b1; last_sc = '0; stalled = 1'b0;
    rdy = 1'b1; pi = '0; pj = '0;
    num_steps = 16'(steps);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (stalled && (!fu_valid || fu_body_i !== pi || fu_body_j !== pj)) stable_ok = 1'b0;
      if (done) dones++;
      if (step_count != last_sc) begin
        if (step_count != last_sc + 16'd1) seq_ok = 1'b0;
        last_sc = step_count;
      end
      if (!busy) break;
      rdy      = alt ? !rdy : 1'b1;
      fu_ready = rdy;
      if (fu_valid && rdy) hs++;
      stalled = fu_valid && !rdy;
      pi      = fu_body_i;
      pj      = fu_body_j;
      @(negedge clk);
    end
    fu_ready = 1'b1;
  endtask

  int base_x[4]  = '{0, 16, 32, 48};
  int zero4[4]   = '{0, 0, 0, 0};
  int step1_x[4] = '{0, 16, 31, 47};
  int step1_v[4] = '{6, 2, -2, -6};
  int step3_x[4] = '{1, 16, 29, 44};
  int step3_v[4] = '{16, 4, -6, -18};
  int sat_x[4]   = '{-401, 32767, 398, -32768};
  int sat_v[4]   = '{32760, 32767, -32760, -32768};
  int sat_xe[4]  = '{1646, 32767, -1650, -32768};
  int sat_ve[4]  = '{32767, 24575, -32768, -24577};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  dones, hs, cyc, waited;
    bit  stable_ok, seq_ok;
    n_tests = 0; n_fail = 0; lat = 3;
    reset = 1'b1; start = 1'b0; num_steps = '0; host_we = 1'b0; host_addr = '0;
    host_wdata = '0; fu_ready = 1'b1;
    h_start = 1'b0; h_num_steps = '0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    repeat (10) @(negedge clk);

    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset step_count", step_count, 0);
    check("reset fu_valid", fu_valid, 0);
    check("reset fu_body_i", fu_body_i, 0);
    check("reset fu_body_j", fu_body_j, 0);
    check("reset host_rdata", host_rdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // Host path on the 16-body engine.
    h_we = 1'b1; h_addr = 4'd5; h_wdata = mk(100, -7, 3, 0, 9);
    @(negedge clk);
    h_we = 1'b0;
    @(negedge clk);
    check("host write/read body5", h_rdata, mk(100, -7, 3, 0, 9));
    h_num_steps = 16'd1; h_start = 1'b1;
    @(negedge clk);
    h_start = 1'b0;
    @(negedge clk);
    check("host engine busy", h_busy, 1);
    h_we = 1'b1; h_addr = 4'd5; h_wdata = mk(1, 2, 3, 4, 5);
    @(negedge clk);
    h_we = 1'b0;
    @(negedge clk);
    check("host write ignored while busy", h_rdata, mk(100, -7, 3, 0, 9));

    // Single step, ready always high, latency 3.
    lat = 3;
    load(base_x, zero4);
    run(1, 1'b0, dones, hs, cyc, stable_ok, seq_ok);
    check("step1 no timeout", cyc < 3000, 1);
    check("step1 done pulses", dones, 1);
    check("step1 step_count", step_count, 1);
    check("step1 handshakes", hs, 12);
    check_bodies("step1", step1_x, step1_v);

    // Same stimulus, alternating ready, latency 5.
    lat = 5;
    load(base_x, zero4);
    run(1, 1'b1, dones, hs, cyc, stable_ok, seq_ok);
    check("stall no timeout", cyc < 3000, 1);
    check("stall handshakes", hs, 12);
    check("stall operands stable", stable_ok, 1);
    check("stall done pulses", dones, 1);
    check_bodies("stall", step1_x, step1_v);

    // Saturation of velocity and position in both directions.
    lat = 3;
    load(sat_x, sat_v);
    run(1, 1'b0, dones, hs, cyc, stable_ok, seq_ok);
    check("sat done pulses", dones, 1);
    check_bodies("sat", sat_xe, sat_ve);

    // Zero-step run: immediate done, memory and bank untouched.
    run(0, 1'b0, dones, hs, cyc, stable_ok, seq_ok);
    check("zero done pulses", dones, 1);
    check("zero run length", cyc, 1);
    check("zero handshakes", hs, 0);
    check("zero step_count", step_count, 0);
    check_bodies("zero", sat_xe, sat_ve);

    // Three chained steps in one run.
    load(base_x, zero4);
    run(3, 1'b0, dones, hs, cyc, stable_ok, seq_ok);
    check("three done pulses", dones, 1);
    check("three step_count", step_count, 3);
    check("three step_count sequence", seq_ok, 1);
    check("three handshakes", hs, 36);
    check_bodies("three", step3_x, step3_v);

    // Reset in the middle of ISSUE while results are still in flight.
    load(base_x, zero4);
    num_steps = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!fu_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("reach issue", fu_valid, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset fu_valid", fu_valid, 0);
    check("midreset step_count", step_count, 0);
    repeat (8) @(negedge clk);
    check("late results ignored", busy, 0);
    load(base_x, zero4);
    run(1, 1'b0, dones, hs, cyc, stable_ok, seq_ok);
    check("post-reset done pulses", dones, 1);
    check("post-reset handshakes", hs, 12);
    check_bodies("post-reset", step1_x, step1_v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nbody_step_engine.md
# nbody_step_engine

Parametrised N-body time-step sequencer: holds all body states in internal ping-pong banks, streams every ordered (i, j≠i) pair to an external pipelined force unit over a valid/ready handshake, accumulates returned forces per body, and applies a saturating semi-implicit Euler update. It runs a host-selected number of steps. It supersedes the single-outstanding-request simulation FSM, adding multi-step runs, pipelined issue, back-pressure and the integration stage. It sits between the host load/readout path and the force pipeline.

## Interface
- N, 16: body count, ≥2; AW = $clog2(N)
- W, 16: signed width of x, y, vx, vy
- MW, 16: unsigned mass width; body word BW = 4W+MW, packed {x, y, vx, vy, mass}
- FW, 32: signed force-result width
- DT_SHIFT, 4: dt = 2^-DT_SHIFT (arithmetic right shift)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin run (sampled in IDLE only)
- num_steps  in  16  steps to run; latched on start
- busy  out  1  high from cycle after accepted start until DONE exits
- done  out  1  one-cycle pulse at end of run
- step_count  out  16  completed steps in current/last run
- host_we  in  1  write body word; ignored while busy
- host_addr  in  AW  body index
- host_wdata  in  BW  body word
- host_rdata  out  BW  registered read of current bank
- fu_valid  out  1  pair offered
- fu_ready  in  1  force unit accepts
- fu_body_i, fu_body_j  out  BW each  pair operands; 0 when fu_valid low
- fu_res_valid  in  1  result strobe, in issue order
- fu_fx, fu_fy  in  FW each  signed force contributions

## Operation
- Two banks of N words; bank_sel picks current. Host reads/writes current. Memory is not reset.
- States: IDLE, LOAD_I, ISSUE, DRAIN, UPDATE, SWAP, DONE.
- IDLE: start → latch num_steps, step_count←0, i←0. If num_steps=0, go to DONE; otherwise go to LOAD_I. Start while busy is ignored.
- LOAD_I: latch body i, clear accumulators ax, ay and issued/received counters, set j to first index ≠ i → ISSUE.
- ISSUE: fu_valid=1 with body i and body j from current bank.
  - On fu_valid&fu_ready, advance j, skipping i.
  - After N−1 handshakes → DRAIN.
  - fu_valid/j are stable while fu_ready=0.
- ISSUE and DRAIN: each fu_res_valid adds fu_fx/fu_fy to ax/ay, which are signed FW+AW bits and never overflow. fu_res_valid in any other state is ignored.
- DRAIN: when received = N−1 → UPDATE. A result may complete in the same cycle as the last issue.
- UPDATE: compute at widened width, sat() clamping to [−2^(W−1), 2^(W−1)−1].
  - vx' = sat(vx + (ax>>>DT_SHIFT)); x' = sat(x + (vx'>>>DT_SHIFT)); same for y.
  - Write {x', y', vx', vy', mass} to the other bank at i.
  - If i=N−1 → SWAP; otherwise i++ → LOAD_I.
- SWAP: toggle bank_sel, step_count++. If step_count+1 = num_steps → DONE; otherwise i←0 → LOAD_I.
- DONE: done=1 for one cycle → IDLE.
- Reset (any state): IDLE, bank_sel=0, counters cleared, in-flight results ignored.

## Timing
- Reset values: busy 0, done 0, step_count 0, fu_valid 0, fu_body_* 0, host_rdata 0.
- host_rdata = current[host_addr] one cycle after address. A host write followed by a read of the same address returns new data.
- Per body, with fu_ready=1 and force latency L: 1 (LOAD_I) + N−1 (ISSUE) + L (drain tail, ≥0) + 1 (UPDATE).
- Step adds 1 SWAP cycle; DONE 1 cycle.
- num_steps=0: done pulses 2 cycles after start (IDLE→DONE).
- Exactly N·(N−1) handshakes per step; none dropped or duplicated under any ready pattern.

## Test plan
Bench force model: fx = xj − xi, fy = yj − yi, latency L.
- Host path: write body 5 = {x=100,y=−7,vx=3,vy=0,m=9}, read addr 5 → host_rdata matches next cycle; host_we while busy leaves memory unchanged.
- N=4, x={0,16,32,48}, y=v=0, DT_SHIFT=4, num_steps=1, L=3, ready=1:
  - final vx={6,2,−2,−6}, x={0,16,31,47}, y/vy=0, masses unchanged.
  - done pulses once; step_count=1.
- Same stimulus, fu_ready alternating 1/0, L=5 → identical results, 12 handshakes counted, fu_body_* stable while stalled.
- Saturation: vx=32760, ax giving dv=100 → vx'=32767; x=32767 → x' stays 32767. Negative mirror → −32768.
- num_steps=0 → done after 2 cycles, memory unchanged; num_steps=3 → step_count 1,2,3, single done pulse, results equal three chained single steps.
- Reset asserted mid-ISSUE, with late fu_res_valid pulses following it → next cycle busy=0, fu_valid=0, step_count=0. A fresh run then produces correct results.
